img_stream_src: RTL

Video stream source that produces the vs/hs/clken/data pixel stream consumed by the line-buffer and window blocks (for example the 5x5 matrix generator). On a start request it plays one frame out of an external synchronous-read frame memory, raster order, with programmable vertical lead and tail, horizontal blanking and pixel pacing. It sits between the frame buffer and the image-processing chain, and is used both in simulation benches and on-chip.

---
 rtl/img_stream_src_if.sv | 16 +
 rtl/img_stream_src.sv | 107 ++++++++++
 2 files changed

// File: rtl/img_stream_src_if.sv
// img_stream_src_if: frame-memory read port plus video stream bundle of img_stream_src
// Ports: rd_en/rd_addr/rd_data form the synchronous-read memory port (data one clock after rd_en),
//        out_vs/out_hs/out_clken/out_data form the pixel stream; master = stream source, slave = its peer
interface img_stream_src_if #(
    parameter int ADDR_W = 19
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic              out_vs;
    logic              out_hs;
    logic              out_clken;
    logic [15:0]       out_data;
    modport master (output rd_en, rd_addr, out_vs, out_hs, out_clken, out_data, input rd_data);
    modport slave  (input rd_en, rd_addr, out_vs, out_hs, out_clken, out_data, output rd_data);
endinterface

// File: rtl/img_stream_src.sv
// img_stream_src: plays one frame from a sync-read frame memory as a vs/hs/clken/data pixel stream
// Ports: clk, rst_n (async, active low), frame_start (sampled only in IDLE), busy, frame_done (1-clock pulse),
//        bus (master): rd_en/rd_addr/rd_data to the frame memory, out_vs/out_hs/out_clken/out_data downstream
module img_stream_src #(
    parameter int IMG_H     = 800,
    parameter int IMG_V     = 600,
    parameter int H_BLANK   = 16,
    parameter int V_LEAD    = 4,
    parameter int V_TAIL    = 4,
    parameter int CLKEN_DIV = 1,
    parameter int ADDR_W    = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    output logic busy,
    output logic frame_done,
    img_stream_src_if.master bus
);
    localparam int BMAX = (V_LEAD > H_BLANK) ? ((V_LEAD > V_TAIL) ? V_LEAD : V_TAIL)
                                             : ((H_BLANK > V_TAIL) ? H_BLANK : V_TAIL);
    localparam int SW = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;
    localparam int PW = $clog2(IMG_H);
    localparam int LW = (IMG_V > 1) ? $clog2(IMG_V) : 1;
    localparam int BW = (BMAX > 1) ? $clog2(BMAX) : 1;
    typedef enum logic [2:0] {IDLE, VLEAD, LINE, HBLANK, VTAIL} state_t;
    state_t        state;
    logic [SW-1:0] slot;
    logic [PW-1:0] pix;
    logic [LW-1:0] line;
    logic [BW-1:0] cnt;
    logic          vs_d1, hs_d1, ce_d1;
    logic          vs_i, hs_i, clken_i, slot_last, line_last;
    assign vs_i      = state != IDLE;
    assign hs_i      = state == LINE;
    assign slot_last = slot == SW'(CLKEN_DIV - 1);
    assign line_last = slot_last && pix == PW'(IMG_H - 1);
    assign clken_i   = hs_i && slot == '0;
    assign bus.rd_en = clken_i;
    // busy spans the whole frame including the two pipeline stages and the frame_done clock,
    // and stays continuous across back-to-back frames
    assign busy = vs_i | vs_d1 | bus.out_vs | frame_done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            slot          <= '0;
            pix           <= '0;
            line          <= '0;
            cnt           <= '0;
            vs_d1         <= 1'b0;
            hs_d1         <= 1'b0;
            ce_d1         <= 1'b0;
            frame_done    <= 1'b0;
            bus.rd_addr   <= '0;
            bus.out_vs    <= 1'b0;
            bus.out_hs    <= 1'b0;
            bus.out_clken <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            vs_d1         <= vs_i;
            hs_d1         <= hs_i;
            ce_d1         <= clken_i;
            bus.out_vs    <= vs_d1;
            bus.out_hs    <= hs_d1;
            bus.out_clken <= ce_d1;
            // memory answers one clock after rd_en, i.e. when the first delay stage holds the read
            if (ce_d1) bus.out_data <= bus.rd_data;
            frame_done <= bus.out_vs & ~vs_d1;
            if (clken_i) bus.rd_addr <= bus.rd_addr + 1'b1;
            case (state)
                IDLE: if (frame_start) begin
                    state <= VLEAD;
                    cnt   <= '0;
                end
                VLEAD: if (cnt == BW'(V_LEAD - 1)) begin
                    state <= LINE;
                    cnt   <= '0;
                    slot  <= '0;
                    pix   <= '0;
                end else cnt <= cnt + 1'b1;
                LINE: begin
                    slot <= slot_last ? '0 : slot + 1'b1;
                    if (slot_last) pix <= line_last ? '0 : pix + 1'b1;
                    if (line_last) begin
                        cnt <= '0;
                        if (line == LW'(IMG_V - 1)) state <= VTAIL;
                        else begin
                            state <= HBLANK;
                            line  <= line + 1'b1;
                        end
                    end
                end
                HBLANK: if (cnt == BW'(H_BLANK - 1)) begin
                    state <= LINE;
                    cnt   <= '0;
                end else cnt <= cnt + 1'b1;
                VTAIL: if (cnt == BW'(V_TAIL - 1)) begin
                    state       <= IDLE;
                    cnt         <= '0;
                    line        <= '0;
                    bus.rd_addr <= '0;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
